// File: rtl/ff_run_sequencer.sv
// ff_run_sequencer: runs one feed_forward inference pass from a command.
// It checks the command, streams N parameter words from a synchronous
// memory into feed_forward, pulses start, and waits for oldu or a timeout.
module ff_run_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cfg_l1,
  input  logic [3:0]        cfg_l2,
  input  logic [3:0]        cfg_l3,
  input  logic [3:0]        cfg_l4,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [3:0]        ff_first,
  output logic [3:0]        ff_second,
  output logic [3:0]        ff_third,
  output logic [3:0]        ff_fourth,
  output logic              ff_load,
  output logic [DATA_W-1:0] ff_data,
  output logic              ff_start,
  input  logic              ff_oldu,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Wait counter holds 0..TIMEOUT-1; range check needs room for base + 735.
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = ADDR_W + 11;
  localparam logic [SW-1:0] ADDR_SPAN = SW'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_LOAD, S_STREAM, S_GAP, S_START, S_WAIT
  } state_t;

  state_t state, state_n;

  logic [3:0]        l1_q, l2_q, l3_q, l4_q;
  logic [ADDR_W-1:0] base_q;
  logic [9:0]        n_q;
  logic [9:0]        n_calc;
  logic [9:0]        cnt;
  logic [TW-1:0]     wcnt;
  logic              rd_d1;
  logic [DATA_W-1:0] data_q;
  logic              done_n, err_n;
  logic              zero_layer, range_bad;
  logic              accept, show_cfg;
  logic [SW-1:0]     end_addr;

  assign accept = (state == S_IDLE) && cmd_valid;

  // Word count of the whole network (max 735, fits 10 bits).
  always_comb begin
    n_calc = 10'(cfg_l1)
           + 10'(cfg_l1) * 10'(cfg_l2) + 10'(cfg_l2)
           + 10'(cfg_l2) * 10'(cfg_l3) + 10'(cfg_l3)
           + 10'(cfg_l3) * 10'(cfg_l4) + 10'(cfg_l4);
  end

  // Command legality, evaluated on the latched copy during CHECK.
  always_comb begin
    zero_layer = (l1_q == 4'd0) || (l2_q == 4'd0) ||
                 (l3_q == 4'd0) || (l4_q == 4'd0);
    end_addr   = SW'(base_q) + SW'(n_q);
    range_bad  = end_addr > ADDR_SPAN;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  // Next-state logic; done/err are decided here and registered below so
  // they appear in the first IDLE cycle together with cmd_ready.
  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      S_IDLE:   if (cmd_valid) state_n = S_CHECK;
      S_CHECK: begin
        if (zero_layer || range_bad) begin
          err_n   = 1'b1;
          state_n = S_IDLE;
        end else begin
          state_n = S_LOAD;
        end
      end
      S_LOAD:   state_n = S_STREAM;
      // cnt reaches N on the cycle the last word is presented.
      S_STREAM: if (cnt == n_q) state_n = S_GAP;
      S_GAP:    state_n = S_START;
      S_START:  state_n = S_WAIT;
      S_WAIT: begin
        if (ff_oldu) begin
          done_n  = 1'b1;
          state_n = S_IDLE;
        end else if (wcnt == TW'(TIMEOUT - 1)) begin
          err_n   = 1'b1;
          state_n = S_IDLE;
        end
      end
      default:  state_n = S_IDLE;
    endcase
  end

  // Command latch: sizes, base and word count captured on accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      l1_q   <= '0;
      l2_q   <= '0;
      l3_q   <= '0;
      l4_q   <= '0;
      base_q <= '0;
      n_q    <= '0;
    end else if (accept) begin
      l1_q   <= cfg_l1;
      l2_q   <= cfg_l2;
      l3_q   <= cfg_l3;
      l4_q   <= cfg_l4;
      base_q <= base_addr;
      n_q    <= n_calc;
    end
  end

  // Stream word counter and oldu timeout counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      wcnt <= '0;
    end else begin
      if (state == S_LOAD)        cnt <= 10'd1;
      else if (state == S_STREAM) cnt <= cnt + 10'd1;
      if (state == S_START)       wcnt <= '0;
      else if (state == S_WAIT)   wcnt <= wcnt + TW'(1);
    end
  end

  // Read-return tracking and hold register for the last delivered word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_d1  <= 1'b0;
      data_q <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      rd_d1 <= mem_rd;
      if (rd_d1) data_q <= mem_data;
      done  <= done_n;
      err   <= err_n;
    end
  end

  // Memory reads: word 0 in LOAD, words 1..N-1 in STREAM; the final
  // STREAM cycle only delivers the last word.
  always_comb begin
    mem_rd   = 1'b0;
    mem_addr = '0;
    if (state == S_LOAD) begin
      mem_rd   = 1'b1;
      mem_addr = base_q;
    end else if (state == S_STREAM && cnt < n_q) begin
      mem_rd   = 1'b1;
      mem_addr = base_q + ADDR_W'(cnt);
    end
  end

  // Word i is forwarded the cycle it returns so it lines up with the read
  // schedule; afterwards the held copy keeps ff_data steady.
  assign ff_data = rd_d1 ? mem_data : data_q;

  // Layer sizes are presented from LOAD until the pass ends.
  assign show_cfg  = (state != S_IDLE) && (state != S_CHECK);
  assign ff_first  = show_cfg ? l1_q : 4'd0;
  assign ff_second = show_cfg ? l2_q : 4'd0;
  assign ff_third  = show_cfg ? l3_q : 4'd0;
  assign ff_fourth = show_cfg ? l4_q : 4'd0;

  assign ff_load   = (state == S_LOAD);
  assign ff_start  = (state == S_START);
  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_ff_run_sequencer.sv
// Directed bench for ff_run_sequencer: a table of commands with hand-computed
// word counts and oldu timing, checked cycle by cycle against the expected
// schedule, plus a hand-written reset-in-stream sequence.
module tb_ff_run_sequencer;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int TO     = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cfg_l1, cfg_l2, cfg_l3, cfg_l4;
  logic [ADDR_W-1:0] base_addr;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [3:0]        ff_first, ff_second, ff_third, ff_fourth;
  logic              ff_load;
  logic [DATA_W-1:0] ff_data;
  logic              ff_start;
  logic              ff_oldu;
  logic              busy, done, err;

  ff_run_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cfg_l1(cfg_l1), .cfg_l2(cfg_l2), .cfg_l3(cfg_l3), .cfg_l4(cfg_l4),
    .base_addr(base_addr), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_data(mem_data), .ff_first(ff_first), .ff_second(ff_second),
    .ff_third(ff_third), .ff_fourth(ff_fourth), .ff_load(ff_load),
    .ff_data(ff_data), .ff_start(ff_start), .ff_oldu(ff_oldu),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Synchronous memory: word at address a holds a+1, data one cycle after rd.
  logic [DATA_W-1:0] mem [256];
  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

  typedef struct {
    logic [3:0] l1, l2, l3, l4;
    logic [7:0] base;
    int         d;      // cycle after accept at which oldu rises (0 = never)
    int         n;      // hand-computed word count
    bit         ok;     // command expected to be accepted
    bit         noise;  // inject cmd_valid and oldu during STREAM
  } vec_t;

  vec_t vt [10];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int c, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle T+%0d got %0h expected %0h", nm, c, act, exp);
    end
  endtask

  // All-outputs-at-reset check: {busy,cmd_ready,load,rd,start,done,err}.
  task automatic chk_reset(input string nm);
    chk({nm, "_ctl"}, 0, 32'({busy, cmd_ready, ff_load, mem_rd, ff_start, done, err}),
        32'b0100000);
    chk({nm, "_data"}, 0, ff_data, 32'd0);
    chk({nm, "_addr"}, 0, 32'(mem_addr), 32'd0);
    chk({nm, "_sizes"}, 0, 32'({ff_first, ff_second, ff_third, ff_fourth}), 32'd0);
  endtask

  // One full command: accept at cycle T, then check every cycle T+1..T+e.
  task automatic run_pass(input vec_t v);
    int e;
    int w;
    logic ex_busy, ex_load, ex_rd, ex_start, ex_done, ex_err;
    @(negedge clk);
    chk("ready_before_cmd", 0, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cfg_l1 = v.l1; cfg_l2 = v.l2; cfg_l3 = v.l3; cfg_l4 = v.l4;
    base_addr = v.base;
    if (!v.ok)         e = 2;
    else if (v.d > 0)  e = v.d + 1;
    else               e = v.n + 5 + TO;
    for (int c = 1; c <= e; c++) begin
      @(negedge clk);
      ex_busy  = (c < e);
      ex_done  = v.ok && (v.d > 0) && (c == e);
      ex_err   = (c == e) && !ex_done;
      ex_load  = v.ok && (c == 2);
      ex_start = v.ok && (c == v.n + 4);
      ex_rd    = v.ok && (c >= 2) && (c <= v.n + 1);
      chk("ctl", c, 32'({busy, cmd_ready, ff_load, mem_rd, ff_start, done, err}),
          32'({ex_busy, !ex_busy, ex_load, ex_rd, ex_start, ex_done, ex_err}));
      if (ex_rd) begin
        w = int'(v.base) + c - 2;
        chk("mem_addr", c, 32'(mem_addr), 32'(w));
      end
      if (v.ok && c >= 3 && c <= v.n + 3) begin
        w = (c <= v.n + 2) ? int'(v.base) + c - 2 : int'(v.base) + v.n;
        chk("ff_data", c, ff_data, 32'(w));
      end
      if (v.ok && c >= 2 && c < e)
        chk("ff_sizes", c, 32'({ff_first, ff_second, ff_third, ff_fourth}),
            32'({v.l1, v.l2, v.l3, v.l4}));
      // Inputs for this cycle's closing edge.
      if (c == 1) begin
        cmd_valid = 1'b0;
        cfg_l1 = 4'hf; cfg_l2 = 4'hf; cfg_l3 = 4'hf; cfg_l4 = 4'hf;
        base_addr = 8'hff;
      end
      ff_oldu = (v.d > 0) && (c >= v.d) && (c < e);
      if (v.noise && c == 20) begin
        cmd_valid = 1'b1;
        cfg_l1 = 4'd1; cfg_l2 = 4'd2; cfg_l3 = 4'd1; cfg_l4 = 4'd2;
        base_addr = 8'd5;
        ff_oldu = 1'b1;
      end
      if (v.noise && c == 21) cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0;
    ff_oldu   = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 32'(a + 1);
    //         l1    l2    l3    l4    base    d    n   ok    noise
    vt[0] = '{4'd4, 4'd6, 4'd5, 4'd3, 8'd0,   100, 87, 1'b1, 1'b0}; // nominal
    vt[1] = '{4'd4, 4'd0, 4'd5, 4'd3, 8'd0,   0,   0,  1'b0, 1'b0}; // zero layer
    vt[2] = '{4'd4, 4'd6, 4'd5, 4'd3, 8'd170, 0,   87, 1'b0, 1'b0}; // 257 > 256
    vt[3] = '{4'd4, 4'd6, 4'd5, 4'd3, 8'd169, 0,   87, 1'b1, 1'b0}; // ends at 255, timeout
    vt[4] = '{4'd1, 4'd1, 4'd1, 4'd1, 8'd0,   12,  7,  1'b1, 1'b0}; // oldu first WAIT cycle
    vt[5] = '{4'd15,4'd15,4'd15,4'd15,8'd0,   0,   735,1'b0, 1'b0}; // max N overflows
    vt[6] = '{4'd2, 4'd3, 4'd1, 4'd4, 8'd200, 43,  23, 1'b1, 1'b0}; // oldu on last wait cycle
    vt[7] = '{4'd2, 4'd3, 4'd1, 4'd4, 8'd233, 40,  23, 1'b1, 1'b0}; // exact fit 256
    vt[8] = '{4'd2, 4'd3, 4'd1, 4'd4, 8'd234, 0,   23, 1'b0, 1'b0}; // one past fit
    vt[9] = '{4'd4, 4'd6, 4'd5, 4'd3, 8'd0,   100, 87, 1'b1, 1'b1}; // busy command ignored

    rst = 1'b0; cmd_valid = 1'b0; ff_oldu = 1'b0;
    cfg_l1 = '0; cfg_l2 = '0; cfg_l3 = '0; cfg_l4 = '0; base_addr = '0;
    #12;
    chk_reset("reset");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) run_pass(vt[i]);

    // Reset in the middle of STREAM, then the same command replays cleanly.
    @(negedge clk);
    cmd_valid = 1'b1;
    cfg_l1 = 4'd4; cfg_l2 = 4'd6; cfg_l3 = 4'd5; cfg_l4 = 4'd3; base_addr = 8'd0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) cmd_valid = 1'b0;
    end
    chk("mid_stream_data", 40, ff_data, 32'd38);
    rst = 1'b0;
    #1;
    chk_reset("abort");
    @(negedge clk);
    chk_reset("abort_hold");
    rst = 1'b1;
    run_pass(vt[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ff_run_sequencer.md
# ff_run_sequencer

Controller that runs one inference pass of the `feed_forward` network from a command. It fetches the network's parameter/input words from a synchronous memory and drives the network's `load`/`data`/`start` protocol and layer-size inputs. It waits for `oldu`, then reports completion or error. It sits between the host/command logic and `feed_forward`, and is the only block that drives `feed_forward`.

## Interface
- `ADDR_W`, 8, memory address width
- `DATA_W`, 32, word width (matches `feed_forward.data`)
- `TIMEOUT`, 4096, max cycles to wait for `oldu` after `start`
- `clk`  input  1  system clock, rising edge
- `rst`  input  1  reset, asynchronous and active-low
- `cmd_valid`  input  1  command request
- `cmd_ready`  output  1  high only in IDLE
- `cfg_l1`..`cfg_l4`  input  4 each  layer sizes, sampled on command accept
- `base_addr`  input  ADDR_W  first memory word, sampled on command accept
- `mem_rd`  output  1  memory read strobe
- `mem_addr`  output  ADDR_W  read address
- `mem_data`  input  DATA_W  read data, valid exactly 1 cycle after `mem_rd`
- `ff_first`, `ff_second`, `ff_third`, `ff_fourth`  output  4 each  to `feed_forward` layer inputs
- `ff_load`  output  1  to `feed_forward.load`
- `ff_data`  output  DATA_W  to `feed_forward.data`
- `ff_start`  output  1  to `feed_forward.start`
- `ff_oldu`  input  1  from `feed_forward.oldu` (level)
- `busy`  output  1  high in every state except IDLE
- `done`  output  1  1-cycle pulse on success
- `err`  output  1  1-cycle pulse on rejected command or timeout

## Operation
- Word count: N = l1 + l1*l2 + l2 + l2*l3 + l3 + l3*l4 + l4. Compute at 10 bits unsigned; maximum 735, so it cannot overflow.
- The sequencer has seven states.
- IDLE: `cmd_ready`=1. On `cmd_valid`, latch `cfg_*`, `base_addr`, and compute N, then go to CHECK.
- CHECK, 1 cycle: if any layer is 0, or base_addr + N > 2^ADDR_W, pulse `err` and go to IDLE. Otherwise go to LOAD. No address wrap is ever performed.
- LOAD, 1 cycle: `ff_load`=1. `ff_first..ff_fourth` carry the latched sizes and stay stable until the sequencer returns to IDLE. `mem_rd`=1 with `mem_addr`=base.
- STREAM: `mem_rd`=1 on each of the remaining N-1 cycles, addresses base+1..base+N-1. `ff_data` is registered `mem_data`, one new word per cycle. Word i (0..N-1) is driven continuously, never stalled.
- GAP, 1 cycle: no read. `ff_data` holds the last word.
- START, 1 cycle: `ff_start`=1. Clear the timeout counter.
- WAIT: on `ff_oldu`=1, pulse `done` next cycle and go to IDLE. If the counter reaches TIMEOUT with no `oldu`, pulse `err` and go to IDLE.
- A `cmd_valid` seen while `busy` is ignored; it is neither queued nor flagged.
- `oldu` is ignored outside WAIT.

## Timing
- Reset values: `cmd_ready`=1, and every other output is 0, including `ff_data`, `ff_first..ff_fourth` and `mem_addr`. After reset the state is IDLE.
- Reset asserted mid-pass aborts at once and returns all outputs to reset values; neither `done` nor `err` is pulsed.
- Let command accept be the edge ending cycle T. Then:
  - CHECK is at T+1.
  - `ff_load` is high at T+2.
  - `ff_data` = word i at cycle T+3+i.
  - The last word is at T+2+N and is held through T+3+N (GAP).
  - `ff_start` is high at T+4+N.
- `done` or `err` is high exactly one cycle. `cmd_ready` returns high in the same cycle.
- Timeout: if `oldu` never rises, `err` is at T+5+N+TIMEOUT.
- `ff_load`, `ff_start`, `done` and `err` are never high in the same cycle.

## Test plan
- Nominal pass: cfg 4,6,5,3, base 0, memory word k = k+1 → N=87.
  - `ff_load` at T+2.
  - `ff_data` = 1..87 at T+3..T+89.
  - `ff_start` at T+91.
  - Model `oldu` high at T+100; `done` must pulse at T+101.
- Reject zero layer: cfg 4,0,5,3 → `err` at T+2, with no `ff_load` and no `mem_rd`.
- Reject address overflow: cfg 4,6,5,3, base 170 (170+87 > 256) → `err` at T+2. Then base 169 is accepted, and its last read address is 255.
- Timeout: TIMEOUT=16 and `oldu` held 0 → `err` at T+5+N+16, with no `done`. A new command is accepted on the next cycle.
- Reset mid-STREAM: drop `rst` at T+40. All outputs go to 0 and `cmd_ready`=1. The next command replays from base with word 0 at T'+3.
- Busy rejection: pulse `cmd_valid` with different cfg during STREAM. The pass continues unchanged, with the same `ff_first..ff_fourth` and a single `done`.
